crypt_stall_controller: RTL and testbench

- Multi-cycle sequencer for the crypt coprocessor in the single-cycle MIPS core.
- When the decoded instruction selects the crypt result as its register write-back source (RegWriteSrc = 11 with RegWrite high), this block:
  - freezes the PC;
  - suppresses architectural writes;
  - issues a start pulse to the crypt engine;
  - waits for completion;
  - releases one write-back cycle.
- It sits between the decode/control logic, the crypt engine and the PC/register-file write enables.

---
 rtl/crypt_ctrl_pkg.sv | 16 +
 rtl/stall_timeout_counter.sv | 28 ++
 rtl/crypt_stall_controller.sv | 102 ++++++++++
 tb/tb_crypt_stall_controller.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/crypt_ctrl_pkg.sv
// Shared definitions for the crypt stall sequencer and the decode logic
// that raises crypt_req.
package crypt_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WB    = 3'd3,
    ST_ABORT = 3'd4
  } crypt_state_e;

  // RegWriteSrc value that selects the crypt result; decode compares against it.
  localparam logic [1:0] RWSRC_CRYPT = 2'b11;

endpackage

// File: rtl/stall_timeout_counter.sv
// Cycle counter for the crypt WAIT state; expired flags the last permitted
// wait cycle (count == LIMIT-1).
module stall_timeout_counter #(
  parameter int unsigned LIMIT = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count   = count_reg;
  assign expired = (count_reg == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/crypt_stall_controller.sv
// Stalls the core around a multi-cycle crypt operation and releases one
// write-back cycle. Optional WAIT timeout/abort under CRYPT_STALL_TIMEOUT_EN.
module crypt_stall_controller
  import crypt_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crypt_req,
  input  logic       crypt_done,
  output logic       crypt_start,
  output logic       stall,
  output logic       crypt_wb,
  output logic       crypt_timeout,
  output logic [2:0] state_dbg
);

  crypt_state_e state_reg, state_next;
  logic         timeout_hit;

`ifdef CRYPT_STALL_TIMEOUT_EN
  logic [CNT_W-1:0] timeout_count;
  logic             timeout_expired;
  logic             timeout_reg;

  // Cleared while in START so the first WAIT cycle sees count 0.
  stall_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_reg == ST_START),
    .en      (state_reg == ST_WAIT),
    .count   (timeout_count),
    .expired (timeout_expired)
  );

  assign timeout_hit = timeout_expired && (timeout_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_reg <= 1'b0;
    end else if (state_reg == ST_ABORT) begin
      timeout_reg <= 1'b1;
    end
  end

  assign crypt_timeout = timeout_reg;
`else
  assign timeout_hit   = 1'b0;
  assign crypt_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    stall       = 1'b0;
    crypt_start = 1'b0;
    crypt_wb    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        stall = crypt_req;
        if (crypt_req) state_next = ST_START;
      end
      ST_START: begin
        stall       = 1'b1;
        crypt_start = 1'b1;
        state_next  = ST_WAIT;
      end
      ST_WAIT: begin
        stall = 1'b1;
        // A done on the expiry cycle still wins over the abort.
        if (crypt_done)       state_next = ST_WB;
        else if (timeout_hit) state_next = ST_ABORT;
      end
      ST_WB: begin
        crypt_wb   = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ABORT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (rst) begin
      stall       = 1'b0;
      crypt_start = 1'b0;
      crypt_wb    = 1'b0;
    end
  end

  assign state_dbg = state_reg;

endmodule

// File: tb/tb_crypt_stall_controller.sv
// Directed-vector bench for crypt_stall_controller; timeout vectors run only
// when CRYPT_STALL_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=4).
module tb_crypt_stall_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       crypt_req;
  logic       crypt_done;
  logic       crypt_start;
  logic       stall;
  logic       crypt_wb;
  logic       crypt_timeout;
  logic [2:0] state_dbg;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc_no = 0;

  always #5 clk = ~clk;

  crypt_stall_controller #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (7)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .crypt_req     (crypt_req),
    .crypt_done    (crypt_done),
    .crypt_start   (crypt_start),
    .stall         (stall),
    .crypt_wb      (crypt_wb),
    .crypt_timeout (crypt_timeout),
    .state_dbg     (state_dbg)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc_no, obs, exp);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge and checks outputs
  // on the falling edge of the same cycle.
  task automatic cyc(input logic r, input logic q, input logic d,
                     input logic [2:0] es, input logic est, input logic estl,
                     input logic ewb, input logic eto);
    rst        = r;
    crypt_req  = q;
    crypt_done = d;
    @(negedge clk);
    $display("cyc %0d rst=%0b req=%0b done=%0b -> st=%0d start=%0b stall=%0b wb=%0b to=%0b",
             cyc_no, r, q, d, state_dbg, crypt_start, stall, crypt_wb, crypt_timeout);
    check("state", 8'(state_dbg), 8'(es));
    check("start", 8'(crypt_start), 8'(est));
    check("stall", 8'(stall), 8'(estl));
    check("wb", 8'(crypt_wb), 8'(ewb));
    check("timeout", 8'(crypt_timeout), 8'(eto));
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  initial begin
    rst        = 1'b1;
    crypt_req  = 1'b0;
    crypt_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset held with a pending request: stall forced low
    cyc(1, 1, 0, 3'd0, 0, 0, 0, 0);

    // single op: req at 0, done at 5, wb at 6
    cyc(0, 1, 0, 3'd0, 0, 1, 0, 0);
    cyc(0, 1, 0, 3'd1, 1, 1, 0, 0);
    cyc(0, 1, 0, 3'd2, 0, 1, 0, 0);
    cyc(0, 1, 0, 3'd2, 0, 1, 0, 0);
    cyc(0, 1, 0, 3'd2, 0, 1, 0, 0);
    cyc(0, 1, 1, 3'd2, 0, 1, 0, 0);
    cyc(0, 1, 0, 3'd3, 0, 0, 1, 0);
    // back-to-back second op with minimum latency (done two cycles after req)
    cyc(0, 1, 0, 3'd0, 0, 1, 0, 0);
    cyc(0, 1, 0, 3'd1, 1, 1, 0, 0);
    cyc(0, 1, 1, 3'd2, 0, 1, 0, 0);
    cyc(0, 1, 0, 3'd3, 0, 0, 1, 0);
    cyc(0, 0, 0, 3'd0, 0, 0, 0, 0);

    // spurious done in IDLE and in START
    cyc(0, 0, 1, 3'd0, 0, 0, 0, 0);
    cyc(0, 1, 0, 3'd0, 0, 1, 0, 0);
    cyc(0, 1, 1, 3'd1, 1, 1, 0, 0);
    cyc(0, 1, 0, 3'd2, 0, 1, 0, 0);
    cyc(0, 1, 1, 3'd2, 0, 1, 0, 0);
    cyc(0, 1, 0, 3'd3, 0, 0, 1, 0);
    cyc(0, 0, 0, 3'd0, 0, 0, 0, 0);

    // reset mid-WAIT at relative cycle 3, late done at 4
    cyc(0, 1, 0, 3'd0, 0, 1, 0, 0);
    cyc(0, 1, 0, 3'd1, 1, 1, 0, 0);
    cyc(0, 1, 0, 3'd2, 0, 1, 0, 0);
    cyc(1, 1, 0, 3'd2, 0, 0, 0, 0);
    cyc(0, 0, 1, 3'd0, 0, 0, 0, 0);
    cyc(0, 0, 0, 3'd0, 0, 0, 0, 0);

`ifdef CRYPT_STALL_TIMEOUT_EN
    // timeout with TIMEOUT_CYCLES=4: ABORT at relative cycle 6
    cyc(0, 1, 0, 3'd0, 0, 1, 0, 0);
    cyc(0, 1, 0, 3'd1, 1, 1, 0, 0);
    cyc(0, 1, 0, 3'd2, 0, 1, 0, 0);
    cyc(0, 1, 0, 3'd2, 0, 1, 0, 0);
    cyc(0, 1, 0, 3'd2, 0, 1, 0, 0);
    cyc(0, 1, 0, 3'd2, 0, 1, 0, 0);
    cyc(0, 1, 0, 3'd4, 0, 0, 0, 0);
    cyc(0, 0, 0, 3'd0, 0, 0, 0, 1);
    // late done after abort is ignored, flag stays set
    cyc(0, 0, 1, 3'd0, 0, 0, 0, 1);
    // done on the expiry cycle goes to WB
    cyc(0, 1, 0, 3'd0, 0, 1, 0, 1);
    cyc(0, 1, 0, 3'd1, 1, 1, 0, 1);
    cyc(0, 1, 0, 3'd2, 0, 1, 0, 1);
    cyc(0, 1, 0, 3'd2, 0, 1, 0, 1);
    cyc(0, 1, 0, 3'd2, 0, 1, 0, 1);
    cyc(0, 1, 1, 3'd2, 0, 1, 0, 1);
    cyc(0, 1, 0, 3'd3, 0, 0, 1, 1);
    // only reset clears the sticky flag
    cyc(1, 0, 0, 3'd0, 0, 0, 0, 1);
    cyc(0, 0, 0, 3'd0, 0, 0, 0, 0);
`else
    // no timeout build: WAIT holds indefinitely without done
    cyc(0, 1, 0, 3'd0, 0, 1, 0, 0);
    cyc(0, 1, 0, 3'd1, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 3'd2, 0, 1, 0, 0);
    cyc(0, 1, 1, 3'd2, 0, 1, 0, 0);
    cyc(0, 1, 0, 3'd3, 0, 0, 1, 0);
    cyc(0, 0, 0, 3'd0, 0, 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
